// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: execute-stage iterative multiply/divide engine that owns
// the HI/LO register pair.
//   CLK, RST             clock, asynchronous active-low reset
//   START_E, DIV_START_E start multiply / divide (sampled in IDLE only)
//   SIGNED_E             1 = signed operation, latched with the start
//   SrcAE, SrcBE         rs / rt operands (SrcAE also carries MTHI/MTLO data)
//   hi_lo_en_E           MTHI/MTLO write strobe (IDLE only, starts win)
//   hi_lo_reg_control_E  MT target: 1 = HI, 0 = LO
//   HI, LO               architectural HI/LO registers
//   BUSY                 high while the engine is not IDLE
//   DONE                 one-cycle pulse when new HI/LO values become visible
module hilo_muldiv_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START_E,
    input  logic        DIV_START_E,
    input  logic        SIGNED_E,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        hi_lo_en_E,
    input  logic        hi_lo_reg_control_E,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned CW = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(31);

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] count_q,  count_d;
    logic          is_div_q, is_div_d;
    logic          signed_q, signed_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    // Multiply: acc = product, opa = shifted multiplicand, opb = multiplier.
    // Divide:   acc[31:0] = partial remainder, opa[31:0] = divisor,
    //           opb = dividend bits shifting out / quotient bits shifting in.
    logic [PW-1:0] acc_q,    acc_d;
    logic [PW-1:0] opa_q,    opa_d;
    logic [DW-1:0] opb_q,    opb_d;
    logic [DW-1:0] hi_q,     hi_d;
    logic [DW-1:0] lo_q,     lo_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    // Operand magnitudes at start time
    logic [DW-1:0] mag_a, mag_b;
    // Restoring-divide step
    logic [DW:0]   rem_shift;
    logic [DW+1:0] trial;
    // Sign-corrected results used on the FIX edge
    logic          res_neg;
    logic [PW-1:0] mul_res;
    logic [DW-1:0] quot_res, rem_res;

    always_comb begin
        mag_a = (SIGNED_E && SrcAE[DW-1]) ? DW'(32'd0 - SrcAE) : SrcAE;
        mag_b = (SIGNED_E && SrcBE[DW-1]) ? DW'(32'd0 - SrcBE) : SrcBE;

        rem_shift = {acc_q[DW-1:0], opb_q[DW-1]};
        trial     = {1'b0, rem_shift} - {2'b00, opa_q[DW-1:0]};

        res_neg  = signed_q && (sign_a_q ^ sign_b_q);
        mul_res  = res_neg ? PW'(64'd0 - acc_q) : acc_q;
        quot_res = res_neg ? DW'(32'd0 - opb_q) : opb_q;
        // Remainder follows the dividend's sign
        rem_res  = sign_a_q ? DW'(32'd0 - acc_q[DW-1:0]) : acc_q[DW-1:0];
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        signed_d = signed_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START_E || DIV_START_E) begin
                    // Multiply has priority when both starts are raised
                    is_div_d = !START_E;
                    signed_d = SIGNED_E;
                    sign_a_d = SIGNED_E && SrcAE[DW-1];
                    sign_b_d = SIGNED_E && SrcBE[DW-1];
                    acc_d    = '0;
                    opa_d    = PW'(START_E ? mag_a : mag_b);
                    opb_d    = START_E ? mag_b : mag_a;
                    count_d  = '0;
                    state_d  = ST_RUN;
                end else if (hi_lo_en_E) begin
                    if (hi_lo_reg_control_E) begin
                        hi_d = SrcAE;
                    end else begin
                        lo_d = SrcAE;
                    end
                end
            end

            ST_RUN: begin
                count_d = CW'(count_q + CW'(1));
                if (is_div_q) begin
                    // Quotient bit is 1 when the trial subtraction does not go negative
                    if (!trial[DW+1]) begin
                        acc_d = PW'(trial[DW:0]);
                        opb_d = {opb_q[DW-2:0], 1'b1};
                    end else begin
                        acc_d = PW'(rem_shift);
                        opb_d = {opb_q[DW-2:0], 1'b0};
                    end
                end else begin
                    acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                    opa_d = {opa_q[PW-2:0], 1'b0};
                    opb_d = {1'b0, opb_q[DW-1:1]};
                end
                if (count_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_res;
                    lo_d = quot_res;
                end else begin
                    hi_d = mul_res[PW-1:DW];
                    lo_d = mul_res[DW-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            signed_q <= signed_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
